// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared state encoding and sizing helper for seq_shift_add_mult
package seq_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter width able to hold values 0..n.
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/mul_abs_conv.sv
// rtl/mul_abs_conv.sv - magnitude/sign split of an optionally two's-complement operand
module mul_abs_conv #(
   parameter int W = 8
) (
   input  logic [W-1:0] value,
   input  logic         signed_mode,
   output logic [W-1:0] mag,
   output logic         sign
);

   // The most-negative value maps to 2^(W-1), which still fits unsigned in W bits.
   assign sign = signed_mode & value[W-1];
   assign mag  = sign ? (-value) : value;

endmodule

// File: rtl/seq_shift_add_mult.sv
// rtl/seq_shift_add_mult.sv - multi-cycle shift-and-add multiplier with valid/ready handshakes
module seq_shift_add_mult
   import seq_mult_pkg::*;
#(
   parameter int M          = 8,
   parameter int N          = 8,
   parameter int EARLY_EXIT = 0
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [M-1:0]   a,
   input  logic [N-1:0]   b,
   input  logic           signed_mode,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [M+N-1:0] product,
   output logic           busy
);

   localparam int W  = M + N;
   localparam int CW = cnt_w(N);

   state_t         state;
   logic [W-1:0]   acc;
   logic [W-1:0]   mcand;
   logic [N-1:0]   mult;
   logic [CW-1:0]  cnt;
   logic           neg;

   logic [M-1:0]   a_mag;
   logic           a_sign;
   logic [N-1:0]   b_mag;
   logic           b_sign;

   logic [W-1:0]   acc_next;
   logic [N-1:0]   mult_next;
   logic           last;

   mul_abs_conv #(.W(M)) u_abs_a (
      .value       (a),
      .signed_mode (signed_mode),
      .mag         (a_mag),
      .sign        (a_sign)
   );

   mul_abs_conv #(.W(N)) u_abs_b (
      .value       (b),
      .signed_mode (signed_mode),
      .mag         (b_mag),
      .sign        (b_sign)
   );

   always_comb begin
      acc_next  = acc + (mult[0] ? mcand : '0);
      mult_next = mult >> 1;
      last      = (cnt == CW'(N - 1)) || ((EARLY_EXIT != 0) && (mult_next == '0));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         acc     <= '0;
         mcand   <= '0;
         mult    <= '0;
         cnt     <= '0;
         neg     <= 1'b0;
         product <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  neg   <= a_sign ^ b_sign;
                  mcand <= {{N{1'b0}}, a_mag};
                  mult  <= b_mag;
                  acc   <= '0;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               acc   <= acc_next;
               mcand <= mcand << 1;
               mult  <= mult_next;
               cnt   <= cnt + CW'(1);
               if (last) begin
                  // Sign is applied once on the full-width magnitude, modulo 2^(M+N).
                  product <= neg ? (-acc_next) : acc_next;
                  state   <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// tb/tb_seq_shift_add_mult.sv - directed and randomized checks of seq_shift_add_mult
module tb_seq_shift_add_mult;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid0 = 1'b0;
   logic        in_valid1 = 1'b0;
   logic [7:0]  a = '0;
   logic [7:0]  b = '0;
   logic        signed_mode = 1'b0;
   logic        out_ready = 1'b0;

   logic        in_ready0, out_valid0, busy0;
   logic        in_ready1, out_valid1, busy1;
   logic [15:0] product0, product1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   seq_shift_add_mult #(.M(8), .N(8), .EARLY_EXIT(0)) u0 (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid0),
      .in_ready    (in_ready0),
      .a           (a),
      .b           (b),
      .signed_mode (signed_mode),
      .out_valid   (out_valid0),
      .out_ready   (out_ready),
      .product     (product0),
      .busy        (busy0)
   );

   seq_shift_add_mult #(.M(8), .N(8), .EARLY_EXIT(1)) u1 (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid1),
      .in_ready    (in_ready1),
      .a           (a),
      .b           (b),
      .signed_mode (signed_mode),
      .out_valid   (out_valid1),
      .out_ready   (out_ready),
      .product     (product1),
      .busy        (busy1)
   );

   task automatic check(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s.%s observed=0x%0h expected=0x%0h", tag, what, obs, exp);
      end
   endtask

   task automatic wait_done(input int s, output int n, output logic rdy_low);
      n = 0;
      rdy_low = 1'b1;
      while (!(s != 0 ? out_valid1 : out_valid0) && n < 50) begin
         if (s != 0 ? in_ready1 : in_ready0) rdy_low = 1'b0;
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic do_op(input int s, input logic [7:0] ta, input logic [7:0] tb, input logic sm,
                        input logic [15:0] ep, input int lat, input int stall, input string tag);
      int   n;
      logic rdy_low;
      a = ta; b = tb; signed_mode = sm;
      check(tag, "in_ready_idle", {31'b0, (s != 0 ? in_ready1 : in_ready0)}, 32'd1);
      if (s != 0) in_valid1 = 1'b1; else in_valid0 = 1'b1;
      @(posedge clk); #1;
      in_valid0 = 1'b0; in_valid1 = 1'b0;
      wait_done(s, n, rdy_low);
      check(tag, "latency", n, lat);
      check(tag, "product", {16'b0, (s != 0 ? product1 : product0)}, {16'b0, ep});
      check(tag, "in_ready_low", {31'b0, rdy_low}, 32'd1);
      repeat (stall) @(posedge clk);
      #1;
      if (stall > 0) begin
         check(tag, "stall_product", {16'b0, (s != 0 ? product1 : product0)}, {16'b0, ep});
         check(tag, "stall_valid", {31'b0, (s != 0 ? out_valid1 : out_valid0)}, 32'd1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check(tag, "valid_drop", {31'b0, (s != 0 ? out_valid1 : out_valid0)}, 32'd0);
   endtask

   initial begin
      int          n;
      logic        rdy_low;
      logic [15:0] hold;
      logic [7:0]  ra, rb, bm;
      logic        rs;
      logic [15:0] rp;
      int          rl;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check("reset", "in_ready0", {31'b0, in_ready0}, 32'd1);
      check("reset", "out_valid0", {31'b0, out_valid0}, 32'd0);
      check("reset", "busy0", {31'b0, busy0}, 32'd0);
      check("reset", "product0", {16'b0, product0}, 32'd0);
      check("reset", "product1", {16'b0, product1}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Fixed-latency instance, hand-computed vectors.
      do_op(0, 8'd13, 8'd11, 1'b0, 16'h008F, 8, 0, "u13x11");
      do_op(0, 8'hFD, 8'd5,  1'b1, 16'hFFF1, 8, 0, "s_m3x5");
      do_op(0, 8'h80, 8'h80, 1'b1, 16'h4000, 8, 0, "s_min_min");
      do_op(0, 8'h7F, 8'h80, 1'b1, 16'hC080, 8, 0, "s_max_min");
      do_op(0, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 8, 0, "u_ff_ff");

      // Early-exit instance.
      do_op(1, 8'h7F, 8'h01, 1'b0, 16'h007F, 1, 0, "ee_b1");
      do_op(1, 8'h55, 8'h00, 1'b0, 16'h0000, 1, 0, "ee_b0");
      do_op(1, 8'h7F, 8'h80, 1'b0, 16'h3F80, 8, 0, "ee_b80");

      // Back-pressure with a competing request held in DONE.
      a = 8'd9; b = 8'd3; signed_mode = 1'b0;
      in_valid0 = 1'b1;
      @(posedge clk); #1;
      in_valid0 = 1'b0;
      wait_done(0, n, rdy_low);
      check("bp", "latency", n, 8);
      hold = product0;
      check("bp", "product", {16'b0, hold}, 32'd27);
      a = 8'd2; b = 8'd2;
      in_valid0 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp", "held_product", {16'b0, product0}, 32'd27);
         check("bp", "held_valid", {31'b0, out_valid0}, 32'd1);
         check("bp", "held_in_ready", {31'b0, in_ready0}, 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp", "idle_after_hs", {31'b0, in_ready0}, 32'd1);
      @(posedge clk); #1;
      in_valid0 = 1'b0;
      check("bp", "accepted", {31'b0, busy0}, 32'd1);
      wait_done(0, n, rdy_low);
      check("bp", "second_latency", n, 8);
      check("bp", "second_product", {16'b0, product0}, 32'd4);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Asynchronous reset during RUN.
      a = 8'h12; b = 8'h34; signed_mode = 1'b0;
      in_valid0 = 1'b1;
      @(posedge clk); #1;
      in_valid0 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_run", "product", {16'b0, product0}, 32'd0);
      check("rst_run", "out_valid", {31'b0, out_valid0}, 32'd0);
      check("rst_run", "in_ready", {31'b0, in_ready0}, 32'd1);
      check("rst_run", "busy", {31'b0, busy0}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_op(0, 8'd6, 8'd7, 1'b0, 16'd42, 8, 0, "after_rst");

      // Random operands and stalls against a reference multiply.
      for (int k = 0; k < 80; k++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rs = 1'($urandom);
         if (rs) rp = 16'($signed({{8{ra[7]}}, ra}) * $signed({{8{rb[7]}}, rb}));
         else    rp = {8'b0, ra} * {8'b0, rb};
         if (k % 2 == 0) begin
            rl = 8;
         end else begin
            bm = (rs && rb[7]) ? 8'(-rb) : rb;
            rl = 1;
            for (int j = 0; j < 8; j++) if (bm[j]) rl = j + 1;
         end
         do_op(k % 2, ra, rb, rs, rp, rl, int'($urandom_range(0, 3)), "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_shift_add_mult.md
# seq_shift_add_mult

Parametrised multi-cycle shift-and-add multiplier with a valid/ready handshake on both sides and runtime signed/unsigned mode. It processes one multiplier bit per clock and can optionally terminate early when the remaining multiplier bits are zero. It is the area-lean multiplier for datapaths that tolerate N-cycle latency, and it is instantiated behind a producer/consumer pair that follows the standard valid/ready rules.

## Interface
Parameters:
- M, 8, multiplicand (a) width, ≥2
- N, 8, multiplier (b) width, ≥2
- EARLY_EXIT, 0, 1 = finish as soon as the remaining multiplier bits are all zero

Ports:
- clk  in  1  rising-edge clock; the single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands; high only in IDLE
- a  in  M  multiplicand
- b  in  N  multiplier
- signed_mode  in  1  1 = a and b are two's complement; sampled with the operands
- out_valid  out  1  product valid; high only in DONE
- out_ready  in  1  consumer accepts the product
- product  out  M+N  result register
- busy  out  1  high in RUN or DONE

## Operation
- FSM states: IDLE → RUN → DONE → IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready:
    - Latch neg = signed_mode & (a[M-1]^b[N-1]).
    - Latch mcand = |a| zero-extended to M+N bits (|a| = a when unsigned).
    - Latch mult = |b| (N bits).
    - Clear acc=0, cnt=0, then go to RUN.
- Magnitude of the most-negative value (e.g. -128) is 2^(M-1) and fits unsigned in M bits; no overflow.
- RUN, each cycle:
  - acc += mult[0] ? mcand : 0.
  - mcand <<= 1; mult >>= 1; cnt++.
  - Go to DONE when cnt==N-1, or when EARLY_EXIT=1 and the shifted mult==0.
  - On the transition edge, product ← neg ? -acc_next : acc_next, computed modulo 2^(M+N).
- DONE:
  - out_valid=1; product held stable.
  - On out_valid&out_ready go to IDLE.
  - product keeps its value until the next result is written.
- in_valid and operand changes are ignored outside IDLE; signed_mode is never re-sampled mid-operation.
- Unsigned maximum (2^M-1)(2^N-1) fits in M+N bits; a signed result is exact in M+N bits.
- Reset, including mid-operation: state=IDLE, acc/mcand/mult/cnt=0, product=0, out_valid=0, busy=0, in_ready=1. An aborted operation never produces out_valid.

## Timing
- Accept edge = the edge with in_valid&in_ready.
- With EARLY_EXIT=0, out_valid rises exactly N clock edges after the accept edge.
- With EARLY_EXIT=1, latency is 1 + (index of the highest set bit of |b|), with a minimum of 1. b=0 gives latency 1.
- Throughput with out_ready held high:
  - One DONE cycle is always spent (out_valid is high for at least 1 cycle).
  - The next accept is at the earliest one cycle after the handshake edge.
  - Initiation interval = latency + 2.
- in_valid held high while busy: the operands are taken at the first IDLE cycle, not before.
- All outputs are registered or decoded from the state register; there is no combinational path from inputs to outputs.

## Structure
- Package seq_mult_pkg:
  - state enum {IDLE, RUN, DONE}.
  - Function cnt_w(N) = $clog2(N+1).
- Sub-module mul_abs_conv (parameter W):
  - Takes value and signed_mode; returns magnitude and sign.
  - Instantiated twice, once for a and once for b.
- Final negation stays inline in the top-level.

## Test plan
- Unsigned, M=N=8, EARLY_EXIT=0, a=13, b=11 → product=0x008F; out_valid exactly 8 cycles after accept; in_ready low throughout.
- Signed: a=-3 (0xFD), b=5 → 0xFFF1. a=0x80, b=0x80 → 0x4000. a=0x7F, b=0x80 → 0xC080. Unsigned: a=0xFF, b=0xFF → 0xFE01.
- EARLY_EXIT=1: a=0x7F, b=0x01 → 0x007F after 1 cycle. b=0 → 0 after 1 cycle. b=0x80 → a<<7 after 8 cycles.
- Back-pressure: out_ready low for 5 cycles in DONE → product and out_valid stable, in_ready=0. A new in_valid with a=2, b=2 offered meanwhile is not accepted until after the handshake, then yields 4.
- Reset mid-RUN:
  - rst_n low on RUN cycle 3 → product=0, out_valid=0, in_ready=1 immediately (asynchronous).
  - After release, a=6, b=7 → 42 with no trace of the aborted operation.
- Random regression: 10k random a, b, signed_mode with random out_ready stalls, checked against a reference multiply modulo 2^(M+N), for (M,N) = (8,8), (4,12), (16,3).
